// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM row scheduler: FSM state encoding and default geometry.
package mvm_pkg;

  localparam int unsigned DEFAULT_M          = 4;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    COMPUTE,
    DRAIN,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/mvm_batch_counter.sv
// Batch bookkeeping for the row scheduler: batch count, current batch index,
// batch base address and the valid-row mask of the current batch.
module mvm_batch_counter
  import mvm_pkg::*;
#(
  parameter int unsigned M          = DEFAULT_M,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [31:0]           i_total_rows,
  input  logic                  i_advance,
  output logic [31:0]           o_batch_idx,
  output logic                  o_last_batch,
  output logic [ADDR_WIDTH-1:0] o_base_addr,
  output logic [M-1:0]          o_row_mask
);

  logic [31:0] r_total;
  logic [31:0] r_batches;
  logic [31:0] r_batch_idx;
  logic [31:0] w_quot;
  logic        w_rem_nz;
  logic [31:0] w_batches;
  logic [63:0] w_base_row;

  // Quotient plus remainder flag avoids the total+M-1 overflow near 2^32-1.
  assign w_quot    = i_total_rows / 32'(M);
  assign w_rem_nz  = (i_total_rows % 32'(M)) != '0;
  assign w_batches = w_quot + {31'b0, w_rem_nz};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_total     <= '0;
      r_batches   <= '0;
      r_batch_idx <= '0;
    end else if (i_load) begin
      r_total     <= i_total_rows;
      r_batches   <= w_batches;
      r_batch_idx <= '0;
    end else if (i_advance) begin
      r_batch_idx <= r_batch_idx + 32'd1;
    end
  end

  assign w_base_row   = 64'(r_batch_idx) * 64'(M);
  assign o_batch_idx  = r_batch_idx;
  assign o_last_batch = (33'(r_batch_idx) + 33'd1) >= 33'(r_batches);
  assign o_base_addr  = ADDR_WIDTH'(r_batch_idx * 32'(M));

  always_comb begin
    o_row_mask = '0;
    for (int unsigned k = 0; k < M; k++) begin
      o_row_mask[k] = (w_base_row + 64'(k)) < {32'b0, r_total};
    end
  end

endmodule

// File: rtl/mvm_row_scheduler.sv
// Schedules a matrix-vector job as batches of M rows over M parallel row engines.
// Optional MVM_SCHED_PERF_CNT_EN adds the busy_cycles performance counter output.
module mvm_row_scheduler
  import mvm_pkg::*;
#(
  parameter int unsigned NO_OF_ROW_BY_VECTOR_MODULES = DEFAULT_M,
  parameter int unsigned ADDR_WIDTH                  = DEFAULT_ADDR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [31:0]                            total_rows,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   fetch_req,
  output logic [ADDR_WIDTH-1:0]                  fetch_addr,
  input  logic                                   fetch_ack,
  output logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0] eng_start,
  input  logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0] eng_done,
  output logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0] row_mask,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [31:0]                            res_batch
`ifdef MVM_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                            busy_cycles
`endif
);

  localparam int unsigned M = NO_OF_ROW_BY_VECTOR_MODULES;

  sched_state_t r_state;
  sched_state_t w_next;

  logic          w_accept;
  logic          w_rows_done;
  logic          w_advance;
  logic          w_last;
  logic [M-1:0]  w_row_mask;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_rows_done = (eng_done & w_row_mask) == w_row_mask;
  assign w_advance   = (r_state == DRAIN) && res_ready && !w_last;

  mvm_batch_counter #(
    .M          (M),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_batch_counter (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_accept),
    .i_total_rows (total_rows),
    .i_advance    (w_advance),
    .o_batch_idx  (res_batch),
    .o_last_batch (w_last),
    .o_base_addr  (fetch_addr),
    .o_row_mask   (w_row_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != IDLE);
    done      = 1'b0;
    fetch_req = 1'b0;
    eng_start = '0;
    res_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = (total_rows == '0) ? FINISH : FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) w_next = LAUNCH;
      end
      LAUNCH: begin
        eng_start = w_row_mask;
        w_next    = COMPUTE;
      end
      COMPUTE: begin
        if (w_rows_done) w_next = DRAIN;
      end
      DRAIN: begin
        res_valid = 1'b1;
        if (res_ready) w_next = w_last ? FINISH : FETCH;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign row_mask = w_row_mask;

`ifdef MVM_SCHED_PERF_CNT_EN
  logic [31:0] r_busy_cycles;

  always_ff @(posedge clk) begin
    if (reset)                               r_busy_cycles <= '0;
    else if (w_accept)                       r_busy_cycles <= '0;
    else if (busy && (r_busy_cycles != '1))  r_busy_cycles <= r_busy_cycles + 32'd1;
  end

  assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_mvm_row_scheduler.sv
// Self-checking bench for mvm_row_scheduler (M=4, ADDR_WIDTH=16), optionally with MVM_SCHED_PERF_CNT_EN.
module tb_mvm_row_scheduler;

  localparam int M  = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   total_rows;
  logic          busy;
  logic          done;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [M-1:0]  eng_start;
  logic [M-1:0]  eng_done;
  logic [M-1:0]  row_mask;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_batch;
`ifdef MVM_SCHED_PERF_CNT_EN
  logic [31:0]   busy_cycles;
`endif

  always #5 clk = ~clk;

  mvm_row_scheduler #(
    .NO_OF_ROW_BY_VECTOR_MODULES (M),
    .ADDR_WIDTH                  (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .total_rows (total_rows),
    .busy       (busy),
    .done       (done),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .row_mask   (row_mask),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_batch  (res_batch)
`ifdef MVM_SCHED_PERF_CNT_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: job described as a list of batches of at most M rows.
  function automatic longint unsigned m_batches(input logic [31:0] t);
    longint unsigned tt;
    tt = 64'(t);
    return (tt + longint'(M) - 1) / longint'(M);
  endfunction

  function automatic logic [M-1:0] m_mask(input longint unsigned b, input logic [31:0] t);
    longint unsigned remaining;
    longint unsigned valid;
    remaining = 64'(t) - b * longint'(M);
    valid     = (remaining < longint'(M)) ? remaining : longint'(M);
    return M'((64'd1 << valid) - 64'd1);
  endfunction

  function automatic logic [AW-1:0] m_addr(input longint unsigned b);
    return AW'((b * longint'(M)) % (64'd1 << AW));
  endfunction

  logic [AW-1:0] q_addr[$];
  logic [M-1:0]  q_mask[$];
  logic [31:0]   q_resb[$];
  int            n_done;
  int            n_busy;

  // mode 0: immediate handshakes; 1: random; 2: res_ready held low 5 cycles per batch;
  // 3: eng_done exactly the valid rows.
  task automatic run_job(input logic [31:0] total, input int mode, input bit inj);
    bit          finished;
    bit          prev_hold;
    logic [31:0] prev_b;
    int          hold;
    bit          inj_pend;
    bit          injected;
    longint unsigned nb;
    q_addr.delete();
    q_mask.delete();
    q_resb.delete();
    n_done = 0; n_busy = 0; hold = 0;
    finished = 0; prev_hold = 0; prev_b = '0; inj_pend = 0; injected = 0;
    start = 1'b1; total_rows = total;
    fetch_ack = 1'b0; eng_done = '0; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; total_rows = $urandom;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (busy) n_busy++;
      if (done) begin n_done++; finished = 1; end
      if (prev_hold) begin
        chk("hold_res_valid", 64'(res_valid), 64'd1);
        chk("hold_res_batch", 64'(res_batch), 64'(prev_b));
        chk("hold_no_fetch", 64'(fetch_req), 64'd0);
      end
      if (eng_start != '0) q_mask.push_back(eng_start);
      start = 1'b0;
      case (mode)
        1: begin
          fetch_ack = ($urandom % 3) == 0;
          eng_done  = M'($urandom);
          if (($urandom % 3) == 0) eng_done = eng_done | row_mask;
          res_ready = ($urandom % 2) == 0;
        end
        2: begin
          fetch_ack = 1'b1; eng_done = '1;
          res_ready = (hold >= 5);
          if (res_valid && !res_ready) hold++;
          if (res_valid && res_ready) hold = 0;
        end
        3: begin
          fetch_ack = 1'b1; eng_done = row_mask; res_ready = 1'b1;
        end
        default: begin
          fetch_ack = 1'b1; eng_done = '1; res_ready = 1'b1;
        end
      endcase
      if (inj && inj_pend) begin
        start = 1'b1; total_rows = $urandom_range(1, 40);
        eng_done = '0; inj_pend = 0; injected = 1;
      end
      if (inj && !injected && eng_start != '0) inj_pend = 1;
      if (fetch_req && fetch_ack) q_addr.push_back(fetch_addr);
      if (res_valid && res_ready) q_resb.push_back(res_batch);
      prev_hold = res_valid && !res_ready;
      prev_b    = res_batch;
      @(negedge clk);
    end
    start = 1'b0;
    chk("job_terminated", 64'(finished), 64'd1);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
`ifdef MVM_SCHED_PERF_CNT_EN
    chk("busy_cycles", 64'(busy_cycles), 64'(n_busy));
`endif
    nb = m_batches(total);
    chk("done_count", 64'(n_done), 64'd1);
    chk("fetch_count", 64'(q_addr.size()), nb);
    chk("eng_start_count", 64'(q_mask.size()), nb);
    chk("drain_count", 64'(q_resb.size()), nb);
    for (int b = 0; b < q_addr.size() && b < int'(nb); b++)
      chk("fetch_addr", 64'(q_addr[b]), 64'(m_addr(64'(b))));
    for (int b = 0; b < q_mask.size() && b < int'(nb); b++)
      chk("eng_start_mask", 64'(q_mask[b]), 64'(m_mask(64'(b), total)));
    for (int b = 0; b < q_resb.size() && b < int'(nb); b++)
      chk("res_batch", 64'(q_resb[b]), 64'(b));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_fetch_req"}, 64'(fetch_req), 64'd0);
    chk({tag, "_fetch_addr"}, 64'(fetch_addr), 64'd0);
    chk({tag, "_eng_start"}, 64'(eng_start), 64'd0);
    chk({tag, "_row_mask"}, 64'(row_mask), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_batch"}, 64'(res_batch), 64'd0);
`ifdef MVM_SCHED_PERF_CNT_EN
    chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd0);
`endif
  endtask

  typedef struct {
    logic [31:0] total;
    int          exp_fetches;
    logic [M-1:0] last_mask;
    int          exp_busy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cnt;
    tbl[0] = '{total: 32'd8,  exp_fetches: 2, last_mask: 4'b1111, exp_busy: 9};
    tbl[1] = '{total: 32'd6,  exp_fetches: 2, last_mask: 4'b0011, exp_busy: 9};
    tbl[2] = '{total: 32'd0,  exp_fetches: 0, last_mask: 4'b0000, exp_busy: 1};
    tbl[3] = '{total: 32'd1,  exp_fetches: 1, last_mask: 4'b0001, exp_busy: 5};
    tbl[4] = '{total: 32'd4,  exp_fetches: 1, last_mask: 4'b1111, exp_busy: 5};
    tbl[5] = '{total: 32'd13, exp_fetches: 4, last_mask: 4'b0001, exp_busy: 17};

    reset = 1'b1; start = 1'b0; total_rows = '0;
    fetch_ack = 1'b0; eng_done = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].total, 0, 0);
      chk("tbl_fetches", 64'(q_addr.size()), 64'(tbl[i].exp_fetches));
      chk("tbl_last_mask", 64'((q_mask.size() > 0) ? q_mask[q_mask.size()-1] : '0), 64'(tbl[i].last_mask));
      chk("tbl_busy", 64'(n_busy), 64'(tbl[i].exp_busy));
    end

    run_job(32'd6, 3, 0);
    for (int i = 0; i < 8; i++) run_job(32'($urandom_range(0, 23)), 1, 0);
    run_job(32'd9, 2, 0);
    run_job(32'd10, 1, 1);

    // Huge job: checks ceil division near 2^32-1, then reset during COMPUTE of batch 1.
    q_addr.delete(); q_mask.delete();
    start = 1'b1; total_rows = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0; fetch_ack = 1'b1; eng_done = '0; res_ready = 1'b1;
    cnt = 0;
    for (int cyc = 0; cyc < 100 && cnt < 2; cyc++) begin
      if (eng_start != '0) begin q_mask.push_back(eng_start); cnt++; end
      eng_done = (cnt == 1) ? '1 : '0;
      if (fetch_req && fetch_ack) q_addr.push_back(fetch_addr);
      @(negedge clk);
    end
    eng_done = '0;
    chk("big_fetch_count", 64'(q_addr.size()), 64'd2);
    chk("big_addr1", 64'((q_addr.size() > 1) ? q_addr[1] : '1), 64'd4);
    chk("big_mask1", 64'((q_mask.size() > 1) ? q_mask[1] : '0), 64'hF);
    chk("big_busy", 64'(busy), 64'd1);
    chk("big_compute_no_valid", 64'(res_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midjob");
    reset = 1'b0;
    fetch_ack = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    run_job(32'd4, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mvm_row_scheduler.md
MVM_ROW_SCHEDULER -- requirements
Module: mvm_row_scheduler

Interface
REQ-001 SHALL have parameter NO_OF_ROW_BY_VECTOR_MODULES, default 4, number of parallel row engines (M).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, row-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port start, input, 1, one-cycle job request; total_rows, input, 32, rows in job.
REQ-005 SHALL have port busy, output, 1, job in progress; done, output, 1, one-cycle job-complete pulse.
REQ-006 SHALL have port fetch_req, output, 1, row-batch load request; fetch_addr, output, ADDR_WIDTH, first row of batch; fetch_ack, input, 1, batch loaded.
REQ-007 SHALL have port eng_start, output, M, per-engine start pulse; eng_done, input, M, per-engine result ready (level).
REQ-008 SHALL have port row_mask, output, M, valid-row mask of current batch.
REQ-009 SHALL have port res_valid, output, 1, res_ready, input, 1, result-drain handshake; res_batch, output, 32, index of batch being drained.

Function
REQ-010 SHALL implement states IDLE, FETCH, LAUNCH, COMPUTE, DRAIN, FINISH.
REQ-011 SHALL, in IDLE on start=1, latch total_rows, set batches = ceil(total_rows/M), batch index b=0, go to FETCH next cycle; busy=1 from that cycle.
REQ-012 SHALL, if latched total_rows=0, go IDLE->FINISH, issuing no fetch_req or eng_start.
REQ-013 SHALL hold fetch_req=1 and fetch_addr=b*M (truncated to ADDR_WIDTH) throughout FETCH; fetch_ack=1 moves to LAUNCH next cycle.
REQ-014 SHALL assert eng_start=row_mask for exactly one cycle in LAUNCH, then enter COMPUTE.
REQ-015 SHALL set row_mask bit k=1 iff b*M+k < total_rows; the mask is all-ones except on a partial final batch.
REQ-016 SHALL leave COMPUTE when (eng_done & row_mask)==row_mask, sampled same cycle; eng_done bits outside row_mask are ignored.
REQ-017 SHALL hold res_valid=1 and res_batch=b in DRAIN; transfer on res_valid&res_ready; then b+1<batches -> FETCH with b=b+1, else FINISH.
REQ-018 SHALL pulse done=1 for one cycle in FINISH, then return to IDLE with busy=0.
REQ-019 SHALL ignore start while busy=1; latched job parameters are unaffected.
REQ-020 SHALL allow start in the cycle after done; it begins a new job normally.
REQ-021 SHALL compute ceil division without overflow for total_rows up to 2^32-1.

Reset
REQ-022 SHALL, on reset=1 in any state including mid-job, next cycle: state IDLE, busy=0, done=0, fetch_req=0, fetch_addr=0, eng_start=0, row_mask=0, res_valid=0, res_batch=0, b=0.
REQ-023 SHALL give reset priority over start and all handshake inputs.

Configuration
REQ-024 SHALL support macro MVM_SCHED_PERF_CNT_EN; when defined, adds output busy_cycles (32): cycles with busy=1 in the current/last job, cleared at job accept, saturating at 2^32-1, reset to 0.
REQ-025 SHALL, without MVM_SCHED_PERF_CNT_EN, omit the busy_cycles port and its counter; all other behaviour is identical.

Structure
REQ-026 SHALL place the state enumeration and default M/ADDR_WIDTH constants in shared package mvm_pkg.
REQ-027 SHALL implement batch count/index and row_mask generation in one sub-module, mvm_batch_counter.

Verification
REQ-028 SHALL cover: M=4, total_rows=8, immediate acks/done/ready -> 2 fetches at addr 0,4; row_mask 4'b1111 both; one done pulse.
REQ-029 SHALL cover: total_rows=6 -> 2nd batch fetch_addr=4, row_mask 4'b0011; eng_done=4'b0011 suffices to leave COMPUTE.
REQ-030 SHALL cover: total_rows=0 -> done pulses with no fetch_req and no eng_start.
REQ-031 SHALL cover: res_ready held 0 for 5 cycles -> res_valid, res_batch stable; no new fetch until transfer.
REQ-032 SHALL cover: reset asserted in COMPUTE of batch 1 -> all outputs at reset values next cycle; new start for total_rows=4 completes normally.
REQ-033 SHALL cover: start pulsed during COMPUTE -> ignored, job totals unchanged; with MVM_SCHED_PERF_CNT_EN, busy_cycles equals counted busy cycles.
